// File: rtl/lyra2_burst_fifo_if.sv
// Handshake and status bundle for the Lyra2 burst FIFO.
// The master side feeds words in and drains them; the slave side is the FIFO itself.
interface lyra2_burst_fifo_if #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 128
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  burst_mode;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic [LEVEL_W-1:0]    level;
    logic                  almost_empty;
    logic                  almost_full;
    logic [LEVEL_W-1:0]    hwm;
    logic                  hwm_clr;

    modport master (
        output flush, burst_mode, wr_valid, wr_data, rd_ready, hwm_clr,
        input  wr_ready, rd_valid, rd_data, rd_last, level, almost_empty, almost_full, hwm
    );

    modport slave (
        input  flush, burst_mode, wr_valid, wr_data, rd_ready, hwm_clr,
        output wr_ready, rd_valid, rd_data, rd_last, level, almost_empty, almost_full, hwm
    );
endinterface

// File: rtl/lyra2_burst_fifo.sv
// First-word-fall-through hash FIFO with an optional burst release of PIPELINE_DEPTH words,
// synchronous flush and a high-water-mark monitor.
module lyra2_burst_fifo #(
    parameter int DATA_WIDTH     = 256,
    parameter int DEPTH          = 128,
    parameter int PIPELINE_DEPTH = 8,
    parameter int ALMOST_EMPTY   = PIPELINE_DEPTH,
    parameter int ALMOST_FULL    = DEPTH - PIPELINE_DEPTH
) (
    input logic                clk,
    input logic                rst_n,
    lyra2_burst_fifo_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam int CNT_W   = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;

    localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] AE_L    = LEVEL_W'(ALMOST_EMPTY);
    localparam logic [LEVEL_W-1:0] AF_L    = LEVEL_W'(ALMOST_FULL);
    localparam logic [LEVEL_W-1:0] PD_L    = LEVEL_W'(PIPELINE_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_LD  = CNT_W'(PIPELINE_DEPTH - 1);

    typedef enum logic {IDLE, BURST} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LEVEL_W-1:0]    level_q;
    logic [LEVEL_W-1:0]    hwm_q;
    logic [CNT_W-1:0]      burst_cnt;
    state_t                state;

    logic wr_ready_c;
    logic rd_valid_c;
    logic rd_last_c;
    logic wr_fire;
    logic rd_fire;

    assign wr_ready_c = (level_q < DEPTH_L) & ~bus.flush;

    // In burst mode the consumer sees nothing until a whole burst is held.
    always_comb begin
        rd_valid_c = 1'b0;
        rd_last_c  = 1'b0;
        case (state)
            IDLE:  rd_valid_c = ~bus.burst_mode & (level_q != '0);
            BURST: begin
                rd_valid_c = 1'b1;
                rd_last_c  = (burst_cnt == '0);
            end
            default: ;
        endcase
    end

    assign wr_fire = bus.wr_valid & wr_ready_c;
    assign rd_fire = rd_valid_c & bus.rd_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            burst_cnt <= '0;
            state     <= IDLE;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            burst_cnt <= '0;
            state     <= IDLE;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: ;
            endcase
            // A mode change during a burst only takes effect once back in IDLE.
            case (state)
                IDLE: begin
                    if (bus.burst_mode && (level_q >= PD_L)) begin
                        state     <= BURST;
                        burst_cnt <= CNT_LD;
                    end
                end
                BURST: begin
                    if (rd_fire) begin
                        if (burst_cnt == '0) state <= IDLE;
                        else                 burst_cnt <= burst_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flush leaves the high-water mark alone; only reset or hwm_clr lower it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                hwm_q <= '0;
        else if (bus.hwm_clr)      hwm_q <= level_q;
        else if (level_q > hwm_q)  hwm_q <= level_q;
    end

    assign bus.wr_ready     = wr_ready_c;
    assign bus.rd_valid     = rd_valid_c;
    assign bus.rd_last      = rd_last_c;
    assign bus.rd_data      = mem[rd_ptr];
    assign bus.level        = level_q;
    assign bus.almost_empty = (level_q <= AE_L);
    assign bus.almost_full  = (level_q >= AF_L);
    assign bus.hwm          = hwm_q;
endmodule
